mem_stage_pipe: RTL
===================

Name: mem_stage_pipe

Overview:
- Parametrised memory-access pipeline stage of the processor, placed between EX and WB.
- Registers the EX results and resolves jump / conditional-jump.
- Performs loads and stores over a req/ready handshake to the data memory, which may take several cycles, and stalls upstream while an access is outstanding.
- Generalises the 8-bit single-cycle MEM stage to any data, address and register-index width, adding variable-latency memory and an explicit valid/stall protocol.

Parameters:
- DW, 8: data width (register values, ALU result, memory data).
- AW, 8: data-memory address width; the address is the low AW bits of the ALU result.
- RW, 2: destination-register index width.
- TIMEOUT, 15: cycles waited for mem_ready before aborting; used only with MEM_TIMEOUT_EN.

Ports:
- clock  in  1  stage clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX result present this cycle.
- in_wr  in  1  instruction writes a register.
- in_rm  in  1  instruction is a load.
- in_wm  in  1  instruction is a store.
- in_j  in  1  unconditional jump.
- in_jc  in  1  conditional jump.
- in_neq  in  1  conditional jump tests not-equal; 0 tests equal.
- in_zero  in  1  ALU zero flag.
- in_rd  in  RW  destination register index.
- in_alu  in  DW  ALU result; also the memory address.
- in_regval  in  DW  store data.
- stall  out  1  upstream must hold its inputs.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completes the access this cycle.
- out_valid  out  1  WB payload valid.
- out_wr  out  1  registered in_wr, gated by out_valid.
- out_rm  out  1  registered in_rm.
- out_rd  out  RW  registered in_rd.
- out_data  out  DW  load data for loads, otherwise ALU result.
- branch_taken  out  1  registered jump decision, valid with out_valid.
- mem_err  out  1  sticky timeout flag; tied to 0 unless MEM_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, while reset_n is low):
  - state = IDLE.
  - Every output is 0, including stall, mem_req, out_valid, branch_taken and mem_err.
- FSM states: IDLE, ACCESS.
- IDLE, in_valid=1, in_rm=0 and in_wm=0:
  - Capture the payload; out_valid=1 next cycle (1-cycle latency).
  - out_data = in_alu.
  - stall stays 0.
- IDLE, in_valid=1 with in_rm or in_wm set:
  - Go to ACCESS. Latch rd, wr, alu and regval.
  - Drive mem_req=1, mem_we=in_wm, mem_addr=in_alu[AW-1:0], mem_wdata=in_regval from the next cycle.
  - stall=1 from the next cycle until the completion cycle, inclusive.
- ACCESS:
  - Hold mem_req and all mem_* outputs stable until mem_ready=1.
  - When mem_ready=1: drop mem_req, go to IDLE, out_valid=1 next cycle.
  - out_data = mem_rdata for a load, or the latched ALU result for a store.
- mem_ready received while in IDLE: ignored.
- in_rm and in_wm both set: treated as a store; out_data = ALU result.
- While stall=1, inputs are ignored; upstream holds them.
- out_valid is a single-cycle pulse per instruction. out_valid=0 implies out_wr=0 and branch_taken=0.
- Jump decision: branch_taken = in_j | (in_jc & (in_neq ? ~in_zero : in_zero)). It is captured with the payload and presented with out_valid.
- Reset mid-access: mem_req drops immediately (asynchronously); the pending instruction is discarded.
- Zero-wait memory (mem_ready high in the first ACCESS cycle): 2-cycle total latency and one stall cycle.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A log2(TIMEOUT+1)-bit counter runs in ACCESS.
  - When TIMEOUT cycles pass without mem_ready: abort, return to IDLE, out_valid=1 with out_wr forced to 0 and out_data=0.
  - Set mem_err (sticky until reset).
- Undefined: no counter, the stage waits indefinitely, and mem_err is tied to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE, ACCESS) and default width constants (DW, AW, RW).
- One natural sub-module: mem_jump_resolve, the combinational jump decision, reused by other stages.
- The FSM and pipeline registers stay in mem_stage_pipe.

Test Plan:
- ALU op, in_alu=8'h3C, rd=2, wr=1 -> next cycle out_valid=1, out_data=8'h3C, out_rd=2, stall never high.
- Load from 8'h10, mem_ready after 3 cycles with rdata=8'hA5 -> mem_req high for exactly 3 cycles, mem_addr=8'h10, mem_we=0, stall high for 3 cycles, then out_data=8'hA5 and out_valid pulses once.
- Store of 8'h77 to 8'h20, zero-wait -> mem_we=1, mem_wdata=8'h77 for 1 cycle, out_wr=0 when in_wr=0, 2-cycle latency.
- Conditional jump: jc=1, neq=1, zero=0 -> branch_taken=1; then jc=1, neq=1, zero=1 -> branch_taken=0; then j=1 -> branch_taken=1.
- reset_n low during ACCESS -> mem_req, stall and out_valid drop immediately; after release, IDLE accepts a new op normally.
- MEM_TIMEOUT_EN defined, TIMEOUT=15, mem_ready held low -> abort at cycle 15, out_valid=1 with out_wr=0, mem_err=1 sticky.

Source files
------------

// File: rtl/mem_stage_pipe_pkg.sv
// Shared types and default widths for the MEM stage.
// FSM encoding plus data/address/register-index defaults.
package mem_stage_pipe_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int DefDw      = 8;
   localparam int DefAw      = 8;
   localparam int DefRw      = 2;
   localparam int DefTimeout = 15;

endpackage

// File: rtl/mem_jump_resolve.sv
// Combinational jump decision shared by pipeline stages.
// Unconditional jump, or conditional on (not-)equal zero flag.
module mem_jump_resolve (
   input  logic j,
   input  logic jc,
   input  logic neq,
   input  logic zero,
   output logic taken
);

   assign taken = j | (jc & (neq ? ~zero : zero));

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage between EX and WB with variable-latency data memory.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_pipe
   import mem_stage_pipe_pkg::*;
#(
   parameter int DW      = DefDw,
   parameter int AW      = DefAw,
   parameter int RW      = DefRw,
   parameter int TIMEOUT = DefTimeout
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_valid,
   input  logic          in_wr,
   input  logic          in_rm,
   input  logic          in_wm,
   input  logic          in_j,
   input  logic          in_jc,
   input  logic          in_neq,
   input  logic          in_zero,
   input  logic [RW-1:0] in_rd,
   input  logic [DW-1:0] in_alu,
   input  logic [DW-1:0] in_regval,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          out_valid,
   output logic          out_wr,
   output logic          out_rm,
   output logic [RW-1:0] out_rd,
   output logic [DW-1:0] out_data,
   output logic          branch_taken,
   output logic          mem_err
);

   if (TIMEOUT < 1) begin : gBadTimeout
      $error("TIMEOUT must be at least 1");
   end

   state_t        state;
   state_t        stateNext;
   logic          busy;
   logic          accept;
   logic          issue;
   logic          done;
   logic          abort;
   logic          fire;
   logic          take;
   logic [RW-1:0] rdQ;
   logic          wrQ;
   logic          rmQ;
   logic          weQ;
   logic          takenQ;
   logic [DW-1:0] aluQ;
   logic [DW-1:0] regvalQ;

   mem_jump_resolve uJump (
      .j     (in_j),
      .jc    (in_jc),
      .neq   (in_neq),
      .zero  (in_zero),
      .taken (take)
   );

   assign busy   = (state == ACCESS);
   assign accept = ~busy & in_valid;
   assign issue  = accept & (in_rm | in_wm);
   assign done   = busy & mem_ready;

   // Memory bus is driven straight from the latched payload while busy.
   assign stall     = busy;
   assign mem_req   = busy;
   assign mem_we    = busy & weQ;
   assign mem_addr  = busy ? aluQ[AW-1:0] : '0;
   assign mem_wdata = busy ? regvalQ : '0;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] waitCnt;
   logic          errQ;

   assign abort   = busy & ~mem_ready & (waitCnt == CW'(TIMEOUT - 1));
   assign mem_err = errQ;

   // Count unanswered ACCESS cycles; flag is sticky once an abort happens.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         waitCnt <= '0;
         errQ    <= 1'b0;
      end else begin
         if (busy & ~mem_ready & ~abort) waitCnt <= waitCnt + CW'(1);
         else                            waitCnt <= '0;
         if (abort) errQ <= 1'b1;
      end
   end
`else
   assign abort   = 1'b0;
   assign mem_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   // Next state and the one-cycle WB-fire decision.
   always_comb begin
      stateNext = state;
      fire      = 1'b0;
      unique case (state)
         IDLE: begin
            fire = accept & ~issue;
            if (issue) stateNext = ACCESS;
         end
         ACCESS: begin
            fire = done | abort;
            if (done | abort) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Latch the instruction that goes out to memory; a double flag is a store.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdQ     <= '0;
         wrQ     <= 1'b0;
         rmQ     <= 1'b0;
         weQ     <= 1'b0;
         takenQ  <= 1'b0;
         aluQ    <= '0;
         regvalQ <= '0;
      end else if (issue) begin
         rdQ     <= in_rd;
         wrQ     <= in_wr;
         rmQ     <= in_rm;
         weQ     <= in_wm;
         takenQ  <= take;
         aluQ    <= in_alu;
         regvalQ <= in_regval;
      end
   end

   // WB payload: valid, write-enable and branch are pulses gated by fire.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid    <= 1'b0;
         out_wr       <= 1'b0;
         branch_taken <= 1'b0;
         out_rm       <= 1'b0;
         out_rd       <= '0;
         out_data     <= '0;
      end else begin
         out_valid    <= fire;
         out_wr       <= fire & (busy ? (wrQ & ~abort) : in_wr);
         branch_taken <= fire & (busy ? takenQ : take);
         if (fire) begin
            out_rm <= busy ? rmQ : in_rm;
            out_rd <= busy ? rdQ : in_rd;
            if (abort)               out_data <= '0;
            else if (!busy)          out_data <= in_alu;
            else if (rmQ & ~weQ)     out_data <= mem_rdata;
            else                     out_data <= aluQ;
         end
      end
   end

endmodule
